// File: rtl/vc_pkg.sv
// vc_pkg: shared widths, flit type codes, packet FSM states and error bit indices
package vc_pkg;
   localparam int DW    = 32;
   localparam int VCN   = 4;
   localparam int FT    = 3;
   localparam int DEPTH = 4;
   localparam logic [FT-1:0] HOF = 3'b001;
   localparam logic [FT-1:0] BOF = 3'b010;
   localparam logic [FT-1:0] EOF = 3'b100;
   localparam int ERR_OVF = 0;
   localparam int ERR_VC  = 1;
   localparam int ERR_SEL = 2;
   localparam int ERR_FRM = 3;
   typedef enum logic {IDLE, BUSY} state_t;
   // Single-flit packets carry HOF and EOF together; every other combination is malformed.
   function automatic logic legal_type(input logic [FT-1:0] t);
      return t == HOF || t == BOF || t == EOF || t == (HOF | EOF);
   endfunction
endpackage

// File: rtl/vc_inpbuf_if.sv
// vc_inpbuf_if: link-side flit input plus switch-side head/select and status signals
interface vc_inpbuf_if;
   import vc_pkg::*;
   logic           div;
   logic [DW-1:0]  di;
   logic [FT-1:0]  dit;
   logic [VCN-1:0] divc;
   logic [VCN-1:0] credit;
   logic [VCN-1:0] do_vld;
   logic [VCN-1:0] do_hof;
   logic [VCN-1:0] do_sel;
   logic [DW-1:0]  dout;
   logic [FT-1:0]  dot;
   logic [3:0]     err;
   modport master (output div, di, dit, divc, do_sel, input credit, do_vld, do_hof, dout, dot, err);
   modport slave  (input div, di, dit, divc, do_sel, output credit, do_vld, do_hof, dout, dot, err);
endinterface

// File: rtl/vc_fifo.sv
// vc_fifo: one VC's flit store; caller only pushes when space exists (or a pop frees it)
module vc_fifo #(
   parameter int W     = 35,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q, wp_d, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   assign wp_d    = push_i ? wp_q + 1'b1 : wp_q;
   assign rp_d    = pop_i ? rp_q + 1'b1 : rp_q;
   assign cnt_d   = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
   assign full_o  = cnt_q == (AW + 1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign head_o  = mem_q[rp_q];
   // Pointers and occupancy; reset empties the buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end
   // Storage array needs no reset: occupancy gates visibility
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wp_q] <= din_i;
   end
endmodule

// File: rtl/vc_inpbuf.sv
// vc_inpbuf: per-VC input buffer with credit return and sticky link-protocol checks
module vc_inpbuf
   import vc_pkg::*;
(
   input logic        clk,
   input logic        rst,
   vc_inpbuf_if.slave lnk
);
   logic [VCN-1:0]    wr_vc, push, pop, full, empty, frm;
   logic [DW+FT-1:0]  head [VCN];
   logic [DW+FT-1:0]  mux;
   logic              wr_ok, sel_ok, ovf, hof, eof;
   logic [VCN-1:0]    credit_q;
   logic [3:0]        err_q, err_d;
   state_t            st_q [VCN];
   state_t            st_d [VCN];
   assign wr_ok  = lnk.div & $onehot(lnk.divc);
   assign sel_ok = $onehot(lnk.do_sel) & |(lnk.do_sel & ~empty);
   assign pop    = sel_ok ? lnk.do_sel : '0;
   assign wr_vc  = wr_ok ? lnk.divc : '0;
   // A pop on the same VC in this cycle makes room, so a full VC still accepts
   assign push   = wr_vc & (~full | pop);
   assign ovf    = |(wr_vc & full & ~pop);
   assign hof    = |(lnk.dit & HOF);
   assign eof    = |(lnk.dit & EOF);
   for (genvar g = 0; g < VCN; g++) begin : g_vc
      vc_fifo #(.W(DW + FT), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[g]),
         .pop_i   (pop[g]),
         .din_i   ({lnk.dit, lnk.di}),
         .full_o  (full[g]),
         .empty_o (empty[g]),
         .head_o  (head[g])
      );
   end
   // Packet FSM state per VC
   always_ff @(posedge clk or posedge rst) begin
      if (rst) for (int i = 0; i < VCN; i++) st_q[i] <= IDLE;
      else for (int i = 0; i < VCN; i++) st_q[i] <= st_d[i];
   end
   // Next state follows the stored flit's EOF/HOF bits even when it is malformed
   always_comb begin
      for (int i = 0; i < VCN; i++)
         st_d[i] = !push[i] ? st_q[i] : eof ? IDLE : hof ? BUSY : st_q[i];
   end
   // Framing violation: bad type code, body/tail outside a packet, or header inside one
   always_comb begin
      for (int i = 0; i < VCN; i++)
         frm[i] = push[i] & (!legal_type(lnk.dit) | ((st_q[i] == BUSY) == hof));
   end
   // Head mux of the selected VC; zero unless the selection is a valid single pop
   always_comb begin
      mux = '0;
      for (int i = 0; i < VCN; i++) if (pop[i]) mux = mux | head[i];
   end
   // Sticky error accumulation
   always_comb begin
      err_d          = err_q;
      err_d[ERR_OVF] = err_q[ERR_OVF] | ovf;
      err_d[ERR_VC]  = err_q[ERR_VC] | (lnk.div & !$onehot(lnk.divc));
      err_d[ERR_SEL] = err_q[ERR_SEL] | (|lnk.do_sel & !sel_ok);
      err_d[ERR_FRM] = err_q[ERR_FRM] | |frm;
   end
   // Credit pulses one cycle after each pop, plus error register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit_q <= '0;
         err_q    <= '0;
      end else begin
         credit_q <= pop;
         err_q    <= err_d;
      end
   end
   assign lnk.credit = credit_q;
   assign lnk.err    = err_q;
   assign lnk.do_vld = ~empty;
   for (genvar g = 0; g < VCN; g++) begin : g_hof
      assign lnk.do_hof[g] = ~empty[g] & head[g][DW];
   end
   assign lnk.dout = mux[DW-1:0];
   assign lnk.dot  = mux[DW+FT-1:DW];
endmodule

// File: tb/tb_vc_inpbuf.sv
// tb_vc_inpbuf: directed table, reset corner case and randomized run against a queue model
module tb_vc_inpbuf;
   import vc_pkg::*;
   logic clk = 0;
   logic rst = 1;
   always #5 clk = ~clk;
   vc_inpbuf_if lnk();
   vc_inpbuf dut (.clk(clk), .rst(rst), .lnk(lnk));

   typedef struct {
      logic           div;
      logic [DW-1:0]  di;
      logic [FT-1:0]  dit;
      logic [VCN-1:0] divc;
      logic [VCN-1:0] sel;
      logic [VCN-1:0] vld;
      logic [DW-1:0]  dout;
      logic [VCN-1:0] cred;
      logic [3:0]     err;
   } vec_t;

   int total = 0;
   int bad = 0;
   logic [DW+FT-1:0] mq [VCN][$];
   bit               busy [VCN];
   logic [3:0]       err_m;
   logic [VCN-1:0]   cred_m;
   vec_t             tbl [$];
   vec_t             none;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(logic d, logic [DW-1:0] data, logic [FT-1:0] t, logic [VCN-1:0] vc,
                               logic [VCN-1:0] s, logic [VCN-1:0] v, logic [DW-1:0] o,
                               logic [VCN-1:0] c, logic [3:0] e);
      vec_t r;
      r.div = d; r.di = data; r.dit = t; r.divc = vc; r.sel = s;
      r.vld = v; r.dout = o; r.cred = c; r.err = e;
      return r;
   endfunction

   task automatic drive(input logic d, input logic [DW-1:0] data, input logic [FT-1:0] t,
                        input logic [VCN-1:0] vc, input logic [VCN-1:0] s);
      lnk.div = d; lnk.di = data; lnk.dit = t; lnk.divc = vc; lnk.do_sel = s;
   endtask

   task automatic model_clear();
      for (int i = 0; i < VCN; i++) begin
         mq[i].delete();
         busy[i] = 0;
      end
      err_m = 0;
      cred_m = 0;
   endtask

   // One clock: compare outputs mid-cycle against the model, advance the model, pass the edge
   task automatic step(input bit has_exp, input vec_t v);
      logic [VCN-1:0]   ev, eh, pop;
      logic [DW+FT-1:0] eo;
      logic [FT-1:0]    t;
      int               sv, wv;
      @(negedge clk);
      ev = 0; eh = 0; eo = 0; pop = 0; sv = 0; wv = 0;
      for (int i = 0; i < VCN; i++)
         if (mq[i].size() > 0) begin
            ev[i] = 1;
            eh[i] = mq[i][0][DW];
         end
      for (int i = 0; i < VCN; i++) if (lnk.do_sel[i]) sv = i;
      if ($countones(lnk.do_sel) == 1 && ev[sv]) begin
         eo = mq[sv][0];
         pop = lnk.do_sel;
      end
      if (has_exp) begin
         chk("tbl_vld", 64'(lnk.do_vld), 64'(v.vld));
         chk("tbl_do", 64'(lnk.dout), 64'(v.dout));
         chk("tbl_credit", 64'(lnk.credit), 64'(v.cred));
         chk("tbl_err", 64'(lnk.err), 64'(v.err));
      end
      chk("do_vld", 64'(lnk.do_vld), 64'(ev));
      chk("do_hof", 64'(lnk.do_hof), 64'(eh));
      chk("do", 64'(lnk.dout), 64'(eo[DW-1:0]));
      chk("dot", 64'(lnk.dot), 64'(eo[DW+FT-1:DW]));
      chk("credit", 64'(lnk.credit), 64'(cred_m));
      chk("err", 64'(lnk.err), 64'(err_m));
      if (lnk.do_sel != 0 && pop == 0) err_m[ERR_SEL] = 1;
      if (pop != 0) void'(mq[sv].pop_front());
      cred_m = pop;
      if (lnk.div) begin
         if ($countones(lnk.divc) != 1) err_m[ERR_VC] = 1;
         else begin
            for (int i = 0; i < VCN; i++) if (lnk.divc[i]) wv = i;
            if (mq[wv].size() >= DEPTH) err_m[ERR_OVF] = 1;
            else begin
               t = lnk.dit;
               mq[wv].push_back({t, lnk.di});
               if (!(t inside {3'b001, 3'b010, 3'b100, 3'b101})) err_m[ERR_FRM] = 1;
               if (!busy[wv] && !t[0]) err_m[ERR_FRM] = 1;
               if (busy[wv] && t[0]) err_m[ERR_FRM] = 1;
               if (t[2]) busy[wv] = 0;
               else if (t[0]) busy[wv] = 1;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset: outputs must clear without waiting for an edge
   task automatic do_reset();
      rst = 1;
      #2;
      chk("rst_vld", 64'(lnk.do_vld), 64'(0));
      chk("rst_err", 64'(lnk.err), 64'(0));
      chk("rst_credit", 64'(lnk.credit), 64'(0));
      model_clear();
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      logic [FT-1:0] legal [4];
      logic [VCN-1:0] vc, s;
      int r;
      legal[0] = 3'b001; legal[1] = 3'b010; legal[2] = 3'b100; legal[3] = 3'b101;
      none = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
      tbl.push_back(mk(1, 32'hA5, HOF, 4'b0100, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0100, 4'b0100, 32'hA5, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 4'b0100, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h11, HOF, 4'b0001, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h22, BOF, 4'b0001, 4'b0000, 4'b0001, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h33, BOF, 4'b0001, 4'b0000, 4'b0001, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h44, EOF, 4'b0001, 4'b0000, 4'b0001, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(1, 32'h55, HOF, 4'b0001, 4'b0001, 4'b0001, 32'h11, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0001, 32'h0, 4'b0001, 4'b0000));
      tbl.push_back(mk(1, 32'h66, BOF, 4'b0001, 4'b0000, 4'b0001, 32'h0, 4'b0000, 4'b0000));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0001, 32'h0, 4'b0000, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 4'b0001, 32'h22, 4'b0000, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 4'b0001, 32'h33, 4'b0001, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 4'b0001, 32'h44, 4'b0001, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0001, 4'b0001, 32'h55, 4'b0001, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 4'b0001, 4'b0001));
      tbl.push_back(mk(1, 32'h101, HOF, 4'b0010, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0001));
      tbl.push_back(mk(1, 32'h102, BOF, 4'b0010, 4'b0010, 4'b0010, 32'h101, 4'b0000, 4'b0001));
      tbl.push_back(mk(1, 32'h103, EOF, 4'b0010, 4'b0010, 4'b0010, 32'h102, 4'b0010, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0010, 4'b0010, 32'h103, 4'b0010, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 4'b0010, 4'b0001));
      tbl.push_back(mk(1, 32'h333, BOF, 4'b1000, 4'b0000, 4'b0000, 32'h0, 4'b0000, 4'b0001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b1000, 32'h0, 4'b0000, 4'b1001));
      tbl.push_back(mk(1, 32'h777, HOF, 4'b0011, 4'b0000, 4'b1000, 32'h0, 4'b0000, 4'b1001));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0011, 4'b1000, 32'h0, 4'b0000, 4'b1011));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b1000, 32'h0, 4'b0000, 4'b1111));
      tbl.push_back(mk(0, 0, 0, 0, 4'b1000, 4'b1000, 32'h333, 4'b0000, 4'b1111));
      tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 4'b0000, 32'h0, 4'b1000, 4'b1111));
      do_reset();
      foreach (tbl[k]) begin
         drive(tbl[k].div, tbl[k].di, tbl[k].dit, tbl[k].divc, tbl[k].sel);
         step(1, tbl[k]);
      end
      drive(1, 32'hB1, HOF, 4'b0010, 0);
      step(0, none);
      drive(1, 32'hB2, BOF, 4'b0010, 0);
      step(0, none);
      drive(0, 0, 0, 0, 0);
      chk("pre_rst_vld", 64'(lnk.do_vld), 64'(4'b0010));
      do_reset();
      for (int k = 0; k < 4; k++) step(0, none);
      for (int n = 0; n < 3000; n++) begin
         if (n % 300 == 299) do_reset();
         vc = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         r = $urandom_range(0, 9);
         s = (r < 2) ? 4'b0 : (r < 3) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         drive($urandom_range(0, 3) != 0, $urandom,
               ($urandom_range(0, 9) == 0) ? 3'($urandom) : legal[$urandom_range(0, 3)], vc, s);
         step(0, none);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
